hex_keypad_entry: RTL and testbench
===================================

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV_BITS, default 15: a scan tick occurs once every 2^SCAN_DIV_BITS clocks.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: number of consecutive agreeing scan ticks required for press and for release.
REQ-003 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port: col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port: clear  input  1  synchronous clear of entered value and digit count.
REQ-008 SHALL have port: key_code  output  4  hex code of last accepted key.
REQ-009 SHALL have port: key_valid  output  1  one-clock pulse per accepted key.
REQ-010 SHALL have port: value  output  32  hex digits entered so far, newest in [3:0].
REQ-011 SHALL have port: digit_count  output  4  digits entered, 0..8, saturating.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Divider SHALL be a free-running SCAN_DIV_BITS-bit counter; tick asserts for one clock when the counter is all-ones and wraps.
REQ-014 Column index c (0..3) SHALL drive col = ~(1<<c); c changes only on a tick in SCAN state.
REQ-015 Row index r SHALL be the position of the single low bit of synchronized row (row[0] -> 0).
REQ-016 key_code SHALL equal {r[1:0], c[1:0]}, i.e. r*4+c.
REQ-017 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT.
REQ-018 SCAN, on tick: exactly one row low -> latch r and c, set debounce count to 1, go DEBOUNCE; otherwise advance c (3 wraps to 0).
REQ-019 SCAN, on tick, with two or more rows low: treated as no key; advance c, stay in SCAN.
REQ-020 DEBOUNCE, on tick: same single row low -> increment count; at count = DEBOUNCE_SCANS go PRESSED; any other row pattern -> go SCAN and advance c.
REQ-021 DEBOUNCE_SCANS = 1 SHALL go directly from SCAN to PRESSED on the detection tick.
REQ-022 PRESSED SHALL last exactly one clock: key_valid=1, key_code updated, then go RELEASE_WAIT.
REQ-023 RELEASE_WAIT, on tick: all rows high -> increment release count; any row low -> reset release count to 0.
REQ-024 RELEASE_WAIT SHALL go to SCAN and advance c when the release count reaches DEBOUNCE_SCANS.
REQ-025 A held key SHALL produce exactly one key_valid; no auto-repeat.
REQ-026 col SHALL stay on the latched column throughout DEBOUNCE, PRESSED and RELEASE_WAIT.
REQ-027 On key_valid, value SHALL become {value[27:0], key_code}; digit_count SHALL increment, saturating at 8.
REQ-028 After the 9th and later digits, the oldest digit SHALL shift out of value[31:28].
REQ-029 clear SHALL set value=0 and digit_count=0 next clock.
REQ-030 clear in the same cycle as key_valid: clear SHALL win; key_valid still pulses and key_code still updates.
REQ-031 clear SHALL NOT affect FSM, divider, col or key_code.
REQ-032 Latency: key_valid SHALL assert the clock after the (DEBOUNCE_SCANS-1)th tick following the detection tick.

Reset
REQ-033 rst_n low SHALL immediately force: state=SCAN, c=0, col=4'b1110, divider=0, counts=0, synchronizer=4'b1111, key_valid=0, key_code=0, value=0, digit_count=0.
REQ-034 Reset asserted mid-debounce or mid-release SHALL abandon the key with no key_valid.

Verification (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=3)
REQ-035 Reset: assert rst_n=0 mid-operation -> col=1110, key_valid=0, value=0, digit_count=0 with no clock edge.
REQ-036 Press: hold row=1101 while col=1011 for 6 ticks -> one key_valid, key_code=6, value=0x00000006, digit_count=1; col frozen at 1011 until 3 ticks with rows released.
REQ-037 Bounce: row low for 1 tick, then high -> no key_valid, scanning resumes at next column.
REQ-038 Entry: keys 1..9 in order -> value=0x23456789, digit_count=8.
REQ-039 Multi-key: row=1100 on one column -> no key_valid, col keeps rotating.
REQ-040 Clear collision: clear coincident with key_valid for key A -> value=0, digit_count=0, key_code=0xA, key_valid pulses once.

Source files
------------

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce and a shifting 8-digit entry register.
// One column is driven low per scan tick; a single low row latches the key for debounce.
module hex_keypad_entry #(
  parameter int SCAN_DIV_BITS  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [31:0] value,
  output logic [3:0]  digit_count
);

  localparam int CW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               row_meta, row_sync;
  logic [SCAN_DIV_BITS-1:0] div_q;
  logic                     tick;
  logic [1:0]               c_q, c_d, r_q, r_d, r_now;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic                     one_low, all_high;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
      div_q    <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      div_q    <= div_q + 1'b1;
    end
  end

  assign tick     = &div_q;
  assign all_high = &row_sync;

  always_comb begin
    one_low = 1'b0;
    r_now   = '0;
    unique case (row_sync)
      4'b1110: begin one_low = 1'b1; r_now = 2'd0; end
      4'b1101: begin one_low = 1'b1; r_now = 2'd1; end
      4'b1011: begin one_low = 1'b1; r_now = 2'd2; end
      4'b0111: begin one_low = 1'b1; r_now = 2'd3; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt is shared between press debounce and release debounce
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (one_low) begin
            r_d     = r_now;
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE_SCANS <= 1) ? PRESSED : DEBOUNCE;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (one_low && (r_now == r_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) state_d = PRESSED;
          end else begin
            state_d = SCAN;
            c_d     = c_q + 1'b1;
          end
        end
      end
      PRESSED: begin
        cnt_d   = '0;
        state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (tick) begin
          if (all_high) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = SCAN;
              c_d     = c_q + 1'b1;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Output logic
  always_comb begin
    key_valid = (state_q == PRESSED);
    col       = ~(4'b0001 << c_q);
  end

  // key_code is loaded on entry to PRESSED so it is already valid during the key_valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code <= '0;
    end else if ((state_d == PRESSED) && (state_q != PRESSED)) begin
      key_code <= {r_d, c_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_count <= '0;
    end else if (clear) begin
      value       <= '0;
      digit_count <= '0;
    end else if (key_valid) begin
      value <= {value[27:0], key_code};
      if (digit_count != 4'd8) digit_count <= digit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural 4x4 keypad matrix model.
module tb_hex_keypad_entry;

  logic        clk, rst_n, clear;
  logic [3:0]  row, col, key_code, digit_count;
  logic        key_valid;
  logic [31:0] value;
  logic [15:0] mask;

  int total = 0;
  int bad   = 0;
  int kv_count = 0;
  int col_bad  = 0;
  logic [3:0] kv_code = '0;

  hex_keypad_entry #(.SCAN_DIV_BITS(2), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clear(clear),
    .key_code(key_code), .key_valid(key_valid), .value(value), .digit_count(digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key k = r*4+c pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int k = 0; k < 16; k++)
      if (mask[k] && !col[k % 4]) row[k / 4] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      kv_count <= kv_count + 1;
      kv_code  <= key_code;
    end
    if ($countones(~col) != 1) col_bad <= col_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for col to switch onto target; returns at the first negedge showing it
  task automatic wait_col_enter(input logic [3:0] target, input string tag);
    int ok = 0;
    for (int i = 0; i < 40 && col == target; i++) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col == target) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  task automatic press(input int k, output int pulses, output logic [3:0] code);
    int start = kv_count;
    mask = 16'(1) << k;
    repeat (48) @(negedge clk);
    mask = '0;
    repeat (24) @(negedge clk);
    pulses = kv_count - start;
    code   = kv_code;
  endtask

  initial begin
    int pulses, start, found, col_ok, changes;
    logic [3:0] code, prev;

    rst_n = 1'b0; clear = 1'b0; mask = '0;
    #1;
    chk("por_col", col, 4'b1110);
    chk("por_kv", key_valid, 0);
    chk("por_value", value, 0);
    chk("por_dc", digit_count, 0);
    chk("por_code", key_code, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single key 6 (row 1, column 2)
    start = kv_count;
    mask  = 16'(1) << 6;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (key_valid) begin found = 1; break; end
    end
    chk("k6_found", found, 1);
    chk("k6_code", key_code, 4'h6);
    @(negedge clk);
    chk("k6_kv_one_clk", key_valid, 0);
    chk("k6_value", value, 32'h6);
    chk("k6_dc", digit_count, 1);
    col_ok = 1;
    repeat (20) begin
      @(negedge clk);
      if (col != 4'b1011) col_ok = 0;
    end
    chk("k6_col_held", col_ok, 1);
    mask = '0;
    repeat (6) @(negedge clk);
    chk("k6_col_rel", col, 4'b1011);
    for (int i = 0; i < 40 && col == 4'b1011; i++) @(negedge clk);
    chk("k6_col_next", col, 4'b0111);
    repeat (2) @(negedge clk);
    chk("k6_pulses", kv_count - start, 1);

    // Bounce on key 1: visible for exactly one tick
    start = kv_count;
    wait_col_enter(4'b1101, "bnc_wait");
    mask = 16'(1) << 1;
    repeat (4) @(negedge clk);
    mask = '0;
    repeat (3) @(negedge clk);
    chk("bnc_col_frozen", col, 4'b1101);
    @(negedge clk);
    chk("bnc_col_next", col, 4'b1011);
    repeat (30) @(negedge clk);
    chk("bnc_pulses", kv_count - start, 0);
    chk("bnc_value", value, 32'h6);

    // Clear alone
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_value", value, 0);
    chk("clr_dc", digit_count, 0);
    chk("clr_code", key_code, 4'h6);

    // Keys 1..9
    for (int k = 1; k <= 9; k++) begin
      press(k, pulses, code);
      chk($sformatf("seq_pulses_%0d", k), pulses, 1);
      chk($sformatf("seq_code_%0d", k), code, k);
      if (k == 8) begin
        chk("seq_value_8", value, 32'h12345678);
        chk("seq_dc_8", digit_count, 8);
      end
    end
    chk("seq_value_9", value, 32'h23456789);
    chk("seq_dc_9", digit_count, 8);

    // Keys 0 and 4 share column 0: row reads 1100
    start   = kv_count;
    mask    = (16'(1) << 0) | (16'(1) << 4);
    changes = 0;
    prev    = col;
    repeat (40) begin
      @(negedge clk);
      if (col != prev) changes++;
      prev = col;
    end
    mask = '0;
    repeat (20) @(negedge clk);
    chk("multi_pulses", kv_count - start, 0);
    chk("multi_rotating", changes >= 8, 1);
    chk("multi_value", value, 32'h23456789);

    // Reset while debouncing key 5
    start = kv_count;
    wait_col_enter(4'b1101, "rst_wait");
    mask = 16'(1) << 5;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_kv", key_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_dc", digit_count, 0);
    chk("rst_code", key_code, 0);
    repeat (2) @(negedge clk);
    mask = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_pulses", kv_count - start, 0);
    chk("rst_dc_after", digit_count, 0);

    // Key 3, then key A with clear landing on its key_valid cycle
    press(3, pulses, code);
    chk("k3_pulses", pulses, 1);
    chk("k3_value", value, 32'h3);
    start = kv_count;
    mask  = 16'(1) << 10;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (key_valid) begin found = 1; break; end
    end
    chk("kA_found", found, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("kA_value", value, 0);
    chk("kA_dc", digit_count, 0);
    chk("kA_code", key_code, 4'hA);
    chk("kA_kv_one_clk", key_valid, 0);
    mask = '0;
    repeat (30) @(negedge clk);
    chk("kA_pulses", kv_count - start, 1);
    chk("col_onehot", col_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
